alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 28 ++
 rtl/alu_mc_mul.sv | 54 +++++
 rtl/alu_mc.sv | 148 ++++++++++++++
 tb/tb_alu_mc.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for alu_mc: opcodes, FSM states and flag bit positions.
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_SLTU  = 4'h6;
  localparam logic [3:0] OP_SLL   = 4'h7;
  localparam logic [3:0] OP_SRL   = 4'h8;
  localparam logic [3:0] OP_SRA   = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_MULHU = 4'hB;

  // Flags = {Negative, Zero, Carry, Overflow}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per clock, WIDTH clocks per product.
// done/product are combinational so the final iteration's sum is usable on the edge it completes.
module alu_mc_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;

  always_comb begin
    acc_next = acc_reg;
    if (mplier_reg[0]) acc_next = acc_reg + mcand_reg;
  end

  assign done    = busy_reg && (cnt_reg == CNT_W'(1));
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      cnt_reg    <= CNT_W'(WIDTH);
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg - CNT_W'(1);
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready handshake; single-cycle ops plus optional iterative
// mul/mulhu enabled by macro ALU_MC_MUL_EN (otherwise those opcodes are illegal).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [CTRL_W-1:0] ALUControl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  Result,
  output logic [3:0]        Flags,
  output logic              Illegal
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   diff;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_ill;
  logic               is_mul;
  logic [3:0]         alu_flags;
  logic               accept;

  assign sum_ext = {1'b0, A} + {1'b0, B};
  assign diff    = A - B;
  assign shamt   = B[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    case (ALUControl)
      CTRL_W'(OP_ADD): begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      CTRL_W'(OP_SUB): begin
        alu_res = diff;
        alu_c   = (A >= B);
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      CTRL_W'(OP_AND):  alu_res = A & B;
      CTRL_W'(OP_OR):   alu_res = A | B;
      CTRL_W'(OP_XOR):  alu_res = A ^ B;
      CTRL_W'(OP_SLT):  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      CTRL_W'(OP_SLTU): alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      CTRL_W'(OP_SLL):  alu_res = A << shamt;
      CTRL_W'(OP_SRL):  alu_res = A >> shamt;
      CTRL_W'(OP_SRA):  alu_res = $unsigned($signed(A) >>> shamt);
`ifdef ALU_MC_MUL_EN
      CTRL_W'(OP_MUL), CTRL_W'(OP_MULHU): is_mul = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // Illegal opcodes leave alu_res at zero, so only the flags need masking.
  assign alu_flags = alu_ill ? 4'b0000 : {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};

`ifdef ALU_MC_MUL_EN
  state_t             state_reg;
  state_t             state_next;
  logic               mul_hi_reg;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_sel;

  assign in_ready = (state_reg == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_sel  = mul_hi_reg ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

  alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && is_mul) state_next = MUL;
      MUL:     if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end
`else
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Flags     <= '0;
      Illegal   <= 1'b0;
`ifdef ALU_MC_MUL_EN
      mul_hi_reg <= 1'b0;
`endif
    end else begin
`ifdef ALU_MC_MUL_EN
      if (state_reg == MUL && mul_done) begin
        Result    <= mul_sel;
        Flags     <= {mul_sel[WIDTH-1], (mul_sel == '0), 2'b00};
        Illegal   <= 1'b0;
        out_valid <= 1'b1;
      end else if (accept && is_mul) begin
        // Any pending result was consumed this edge; the product arrives later.
        mul_hi_reg <= (ALUControl == CTRL_W'(OP_MULHU));
        out_valid  <= 1'b0;
      end else
`endif
      if (accept) begin
        Result    <= alu_res;
        Flags     <= alu_flags;
        Illegal   <= alu_ill;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32); mul checks run when ALU_MC_MUL_EN is defined.
module tb_alu_mc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic [3:0]  Flags;
  logic        Illegal;

  int total = 0;
  int bad   = 0;

  alu_mc #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .Flags      (Flags),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One single-cycle op; result must be visible right after the accept edge.
  task automatic alu_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags, input logic exp_ill);
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1'b1);
    in_valid = 1'b1; ALUControl = op; A = a; B = b;
    @(negedge clk);
    in_valid = 1'b0;
    $display("op %h a=%h b=%h -> res=%h flags=%b ill=%b", op, a, b, Result, Flags, Illegal);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_res"}, Result, exp_res);
    chk({tag, "_flg"}, Flags, exp_flags);
    chk({tag, "_ill"}, Illegal, exp_ill);
  endtask

`ifdef ALU_MC_MUL_EN
  task automatic mul_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic [3:0] exp_flags);
    logic early;
    @(negedge clk);
    in_valid = 1'b1; ALUControl = op; A = a; B = b;
    @(negedge clk);
    in_valid = 1'b0;
    early = 1'b0;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      if (out_valid || in_ready) early = 1'b1;
    end
    chk({tag, "_busy"}, early, 1'b0);
    @(negedge clk);
    $display("mul %h a=%h b=%h -> res=%h flags=%b", op, a, b, Result, Flags);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_res"}, Result, exp_res);
    chk({tag, "_flg"}, Flags, exp_flags);
  endtask
`endif

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; ALUControl = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_res", Result, 32'h0);
    chk("rst_flg", Flags, 4'h0);
    chk("rst_ill", Illegal, 1'b0);
    chk("rst_rdy", in_ready, 1'b1);
    rst = 1'b0;

    alu_op("add_ovf",  4'h0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1001, 1'b0);
    alu_op("add_cry",  4'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0110, 1'b0);
    alu_op("sub_zero", 4'h1, 32'd5,        32'd5,        32'h0,        4'b0110, 1'b0);
    alu_op("sub_brw",  4'h1, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b1000, 1'b0);
    alu_op("sub_ovf",  4'h1, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0011, 1'b0);
    alu_op("and",      4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1'b0);
    alu_op("or",       4'h3, 32'h0F,       32'hF0,       32'hFF,       4'b0000, 1'b0);
    alu_op("xor",      4'h4, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0,        4'b0100, 1'b0);
    alu_op("slt",      4'h5, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000, 1'b0);
    alu_op("sltu",     4'h6, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0100, 1'b0);
    alu_op("sll31",    4'h7, 32'h1,        32'd31,       32'h80000000, 4'b1000, 1'b0);
    alu_op("sll_wrap", 4'h7, 32'h1,        32'h20,       32'h1,        4'b0000, 1'b0);
    alu_op("srl",      4'h8, 32'h80000000, 32'd4,        32'h08000000, 4'b0000, 1'b0);
    alu_op("sra",      4'h9, 32'h80000000, 32'h21,       32'hC0000000, 4'b1000, 1'b0);
    alu_op("ill_f",    4'hF, 32'h12345678, 32'h1,        32'h0,        4'b0000, 1'b1);
    alu_op("ill_c",    4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        4'b0000, 1'b1);
`ifndef ALU_MC_MUL_EN
    alu_op("ill_mul",  4'hA, 32'hFFFFFFFF, 32'h2,        32'h0,        4'b0000, 1'b1);
    alu_op("ill_mulh", 4'hB, 32'hFFFFFFFF, 32'h2,        32'h0,        4'b0000, 1'b1);
`endif

    // Backpressure: pending result must hold while a new request waits.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; ALUControl = 4'h0; A = 32'd2; B = 32'd3;
    @(negedge clk);
    A = 32'd10; B = 32'd20;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_vld", out_valid, 1'b1);
      chk("bp_res", Result, 32'd5);
      chk("bp_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    $display("bp release -> res=%h", Result);
    chk("bp_new_vld", out_valid, 1'b1);
    chk("bp_new_res", Result, 32'd30);
    @(negedge clk);
    chk("bp_drain", out_valid, 1'b0);

    // Back-to-back: one result per cycle with in_valid held high.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; ALUControl = 4'h0; A = 32'(i); B = 32'd100;
      @(negedge clk);
      $display("b2b %0d -> res=%h", i, Result);
      chk("b2b_vld", out_valid, 1'b1);
      chk("b2b_res", Result, 32'(i + 100));
      chk("b2b_rdy", in_ready, 1'b1);
    end
    in_valid = 1'b0;

    // Reset wins over a simultaneous accept.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; ALUControl = 4'h0; A = 32'd7; B = 32'd8;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rstpri_vld", out_valid, 1'b0);
    chk("rstpri_res", Result, 32'h0);

`ifdef ALU_MC_MUL_EN
    mul_op("mul",   4'hA, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 4'b1000);
    mul_op("mulhu", 4'hB, 32'hFFFFFFFF, 32'h2, 32'h1,        4'b0000);
    mul_op("mul76", 4'hA, 32'd7,        32'd6, 32'd42,       4'b0000);

    // Reset mid-multiply aborts without producing a result.
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 4'hA; A = 32'd3; B = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy", in_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rdy", in_ready, 1'b1);
    chk("abort_vld", out_valid, 1'b0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_quiet", seen, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
